// File: rtl/ps2_defs.sv
// Shared definitions for the PS/2 host transmitter: FSM encoding, frame
// length and helpers that turn wall-clock parameters into cycle counts.
package ps2_defs;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT_CLK,
    BITS,
    ACK,
    WAIT_IDLE
  } state_t;

  // data[7:0] + odd parity + stop
  localparam int FRAME_LEN = 10;

  function automatic int us_to_cyc(input int clk_hz, input int us);
    return int'((longint'(clk_hz) * longint'(us)) / longint'(1_000_000));
  endfunction

  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return int'((longint'(clk_hz) * longint'(ms)) / longint'(1_000));
  endfunction

  // LSB is shifted out first; the stop bit ends up in the MSB.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one asynchronous PS/2 pad and only follows a new level after it
// has been stable for FILT_LEN cycles; fall pulses on a filtered 1->0 change.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic filt,
  output logic fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable_done;

  assign stable_done = (cnt == CW'(FILT_LEN - 1));

  // An idle PS/2 line floats high, so everything presets to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
      fall <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      sync <= {sync[0], pad};
      fall <= 1'b0;
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (stable_done) begin
        filt <= sync[1];
        fall <= filt;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one
// byte on device-generated edges, then check the device acknowledge.
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int CLK_HZ       = 25_000_000,
  parameter int INHIBIT_US   = 100,
  parameter int SETUP_CYC    = 25,
  parameter int START_TMO_MS = 15,
  parameter int PKT_TMO_MS   = 2,
  parameter int FILT_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       rdy,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err,
  output logic       ps2c_pull,
  output logic       ps2d_pull,
  input  logic       ps2c_in,
  input  logic       ps2d_in
);

  localparam int INH_CYC   = us_to_cyc(CLK_HZ, INHIBIT_US);
  localparam int START_CYC = ms_to_cyc(CLK_HZ, START_TMO_MS);
  localparam int PKT_CYC   = ms_to_cyc(CLK_HZ, PKT_TMO_MS);
  localparam int PH_MAX    = (INH_CYC > SETUP_CYC) ? INH_CYC : SETUP_CYC;
  localparam int TMO_MAX   = (START_CYC > PKT_CYC) ? START_CYC : PKT_CYC;
  localparam int PH_W      = $clog2(PH_MAX + 1);
  localparam int TMO_W     = $clog2(TMO_MAX + 1);
  localparam int BC_W      = $clog2(FRAME_LEN + 1);

  logic filt_c, filt_d, fall_c;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_c (
    .clk  (clk),
    .rst  (rst),
    .pad  (ps2c_in),
    .filt (filt_c),
    .fall (fall_c)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_d (
    .clk  (clk),
    .rst  (rst),
    .pad  (ps2d_in),
    .filt (filt_d),
    .fall ()
  );

  state_t               state, state_n;
  logic [PH_W-1:0]      ph, ph_n, ph_inc;
  logic [TMO_W-1:0]     tmo, tmo_n, tmo_inc;
  logic [FRAME_LEN-1:0] sh, sh_n;
  logic [BC_W-1:0]      bc, bc_n;
  logic                 c_pull_n, d_pull_n, ack_n, err_n, done_n;
  logic                 tmo_hit;

  assign ph_inc  = (ph == PH_W'(PH_MAX)) ? ph : ph + 1'b1;
  assign tmo_inc = (tmo == TMO_W'(TMO_MAX)) ? tmo : tmo + 1'b1;

  // NOTE: the frame register is a plain shift register, not a memory array,
  // so it is reset with everything else to keep the state fully defined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ph        <= '0;
      tmo       <= '0;
      sh        <= '0;
      bc        <= '0;
      ps2c_pull <= 1'b0;
      ps2d_pull <= 1'b0;
      ack_ok    <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      tmo       <= tmo_n;
      sh        <= sh_n;
      bc        <= bc_n;
      ps2c_pull <= c_pull_n;
      ps2d_pull <= d_pull_n;
      ack_ok    <= ack_n;
      err       <= err_n;
      done      <= done_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_n  = state;
    ph_n     = ph_inc;
    tmo_n    = tmo_inc;
    sh_n     = sh;
    bc_n     = bc;
    c_pull_n = ps2c_pull;
    d_pull_n = ps2d_pull;
    ack_n    = ack_ok;
    err_n    = err;
    done_n   = 1'b0;
    tmo_hit  = 1'b0;

    unique case (state)
      IDLE: begin
        c_pull_n = 1'b0;
        d_pull_n = 1'b0;
        if (start) begin
          sh_n     = build_frame(data);
          ack_n    = 1'b0;
          err_n    = 1'b0;
          ph_n     = '0;
          c_pull_n = 1'b1;
          state_n  = INHIBIT;
        end
      end
      INHIBIT: if (ph == PH_W'(INH_CYC - 1)) begin
        ph_n     = '0;
        d_pull_n = 1'b1;
        state_n  = REQ;
      end
      REQ: if (ph == PH_W'(SETUP_CYC - 1)) begin
        c_pull_n = 1'b0;
        tmo_n    = '0;
        state_n  = WAIT_CLK;
      end
      WAIT_CLK: begin
        if (tmo == TMO_W'(START_CYC - 1)) begin
          tmo_hit = 1'b1;
        end else if (fall_c) begin
          d_pull_n = ~sh[0];
          sh_n     = {1'b0, sh[FRAME_LEN-1:1]};
          bc_n     = BC_W'(1);
          tmo_n    = '0;
          state_n  = BITS;
        end
      end
      BITS: begin
        if (tmo == TMO_W'(PKT_CYC - 1)) begin
          tmo_hit = 1'b1;
        end else if (fall_c) begin
          d_pull_n = ~sh[0];
          sh_n     = {1'b0, sh[FRAME_LEN-1:1]};
          bc_n     = bc + 1'b1;
          // bc counts the bit being driven now; index FRAME_LEN-1 is stop
          if (bc == BC_W'(FRAME_LEN - 1)) state_n = ACK;
        end
      end
      ACK: begin
        d_pull_n = 1'b0;
        if (tmo == TMO_W'(PKT_CYC - 1)) begin
          tmo_hit = 1'b1;
        end else if (fall_c) begin
          if (filt_d) err_n = 1'b1;
          else        ack_n = 1'b1;
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (tmo == TMO_W'(PKT_CYC - 1)) begin
          tmo_hit = 1'b1;
        end else if (filt_c && filt_d) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (tmo_hit) begin
      c_pull_n = 1'b0;
      d_pull_n = 1'b0;
      err_n    = 1'b1;
      done_n   = 1'b1;
      state_n  = IDLE;
    end
  end

  assign rdy  = (state == IDLE);
  assign busy = ~rdy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of
// the host, with table-driven byte transfers plus timeout/reset/glitch cases.
module tb_ps2_host_tx;

  // Scaled timing: 1 MHz clock -> 100 inhibit, 15000 start and 2000 packet cycles
  localparam int INH_EXP   = 100;
  localparam int SETUP_EXP = 25;
  localparam int START_EXP = 15000;
  localparam int PKT_EXP   = 2000;
  localparam int H         = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       rdy, busy, done, ack_ok, err, ps2c_pull, ps2d_pull;
  logic       ps2c_in, ps2d_in;
  logic       dev_c, dev_d;

  always #5 clk = ~clk;

  assign ps2c_in = ~(ps2c_pull | dev_c);
  assign ps2d_in = ~(ps2d_pull | dev_d);

  ps2_host_tx #(
    .CLK_HZ      (1_000_000),
    .INHIBIT_US  (100),
    .SETUP_CYC   (25),
    .START_TMO_MS(15),
    .PKT_TMO_MS  (2),
    .FILT_LEN    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .rdy       (rdy),
    .busy      (busy),
    .done      (done),
    .ack_ok    (ack_ok),
    .err       (err),
    .ps2c_pull (ps2c_pull),
    .ps2d_pull (ps2d_pull),
    .ps2c_in   (ps2c_in),
    .ps2d_in   (ps2d_in)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge.
  int inh_cnt = 0, setup_cnt = 0, done_cnt = 0;
  int c_rel_cyc = -1, d_rel_cyc = -1, done_cyc = -1;
  bit armed = 0, done_rdy_bad = 0, prev_c = 0, prev_d = 0;

  always @(negedge clk) begin
    if (ps2c_pull && !ps2d_pull) inh_cnt++;
    if (ps2c_pull && ps2d_pull) setup_cnt++;
    if (prev_c && !ps2c_pull) begin
      c_rel_cyc = cyc;
      armed = 1;
    end
    if (armed && prev_d && !ps2d_pull) begin
      d_rel_cyc = cyc;
      armed = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (!rdy || busy) done_rdy_bad = 1;
    end
    prev_c = ps2c_pull;
    prev_d = ps2d_pull;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [9:0] samp;

  task automatic send_start(input logic [7:0] d);
    @(posedge clk); #1;
    data  = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Device side: wait for the request, optionally glitch CLK, then generate
  // nfalls clock pulses, sampling DAT on each rising edge like a real device.
  task automatic dev_run(input int nfalls, input bit do_ack, input bit glitch);
    int t = 0;
    while (!(ps2c_pull == 1'b0 && ps2d_pull == 1'b1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("request_seen", (t < 2000), 1);
    repeat (10) @(negedge clk);
    if (glitch) begin
      dev_c = 1'b1;
      repeat (3) @(negedge clk);
      dev_c = 1'b0;
      repeat (30) @(negedge clk);
      check("glitch_start_bit_held", ps2d_pull, 1);
      check("glitch_still_busy", busy, 1);
    end
    for (int i = 0; i < nfalls; i++) begin
      if (i == 10 && do_ack) begin
        dev_d = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_c = 1'b1;
      repeat (H) @(negedge clk);
      if (i < 10) samp[i] = ps2d_in;
      dev_c = 1'b0;
      repeat (H) @(negedge clk);
    end
    dev_d = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int t = 0;
    while (done_cnt == base && t < budget) begin
      @(posedge clk);
      t++;
    end
    check(name, (done_cnt != base), 1);
    repeat (5) @(posedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    int         nf;
    bit         ack;
    logic [9:0] frame;
    bit         exp_ack;
    bit         exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_done, b_inh, b_set;

    // frame = {stop, odd parity, data}
    vecs[0] = '{8'hED, 11, 1'b1, 10'h3ED, 1'b1, 1'b0};
    vecs[1] = '{8'hF4, 11, 1'b1, 10'h2F4, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 11, 1'b1, 10'h300, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 11, 1'b1, 10'h3FF, 1'b1, 1'b0};
    vecs[4] = '{8'hED, 11, 1'b0, 10'h3ED, 1'b0, 1'b1};

    rst = 1'b0; start = 1'b0; data = 8'h00; dev_c = 1'b0; dev_d = 1'b0;
    samp = '0;
    repeat (3) @(negedge clk);
    check("rst_rdy", rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_ok", ack_ok, 0);
    check("rst_err", err, 0);
    check("rst_pulls", {ps2c_pull, ps2d_pull}, 2'b00);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      b_done = done_cnt; b_inh = inh_cnt; b_set = setup_cnt;
      samp = '0;
      send_start(vecs[i].d);
      dev_run(vecs[i].nf, vecs[i].ack, 1'b0);
      wait_done(b_done, 300, $sformatf("v%0d_done_seen", i));
      check($sformatf("v%0d_frame", i), samp, vecs[i].frame);
      check($sformatf("v%0d_ack_ok", i), ack_ok, vecs[i].exp_ack);
      check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("v%0d_done_pulses", i), done_cnt - b_done, 1);
      check($sformatf("v%0d_inhibit_cyc", i), inh_cnt - b_inh, INH_EXP);
      check($sformatf("v%0d_setup_cyc", i), setup_cnt - b_set, SETUP_EXP);
      check($sformatf("v%0d_pulls", i), {ps2c_pull, ps2d_pull}, 2'b00);
      check($sformatf("v%0d_rdy", i), rdy, 1);
    end

    // Device never clocks: start timeout measured from CLK release.
    b_done = done_cnt;
    send_start(8'hED);
    wait_done(b_done, 20000, "start_tmo_done_seen");
    check("start_tmo_cycles", done_cyc - c_rel_cyc, START_EXP);
    check("start_tmo_err", err, 1);
    check("start_tmo_ack_ok", ack_ok, 0);
    check("start_tmo_pulls", {ps2c_pull, ps2d_pull}, 2'b00);
    check("start_tmo_done_pulses", done_cnt - b_done, 1);

    // Device stops after 4 bits: packet timeout counted from the cycle the
    // host puts bit0 (a 1, so DAT is released) on the line after the first fall.
    b_done = done_cnt;
    samp = '0;
    send_start(8'hED);
    dev_run(4, 1'b0, 1'b0);
    wait_done(b_done, 3000, "pkt_tmo_done_seen");
    check("pkt_tmo_bits", samp[3:0], 4'b1101);
    check("pkt_tmo_cycles", done_cyc - d_rel_cyc, PKT_EXP);
    check("pkt_tmo_err", err, 1);
    check("pkt_tmo_ack_ok", ack_ok, 0);
    check("pkt_tmo_pulls", {ps2c_pull, ps2d_pull}, 2'b00);

    // CLK glitch while waiting and a start pulse while busy: neither disturbs the frame.
    b_done = done_cnt; b_inh = inh_cnt;
    samp = '0;
    send_start(8'hED);
    repeat (10) @(posedge clk); #1;
    data  = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dev_run(11, 1'b1, 1'b1);
    wait_done(b_done, 300, "glitch_done_seen");
    check("glitch_frame", samp, 10'h3ED);
    check("glitch_ack_ok", ack_ok, 1);
    check("glitch_err", err, 0);
    check("glitch_inhibit_cyc", inh_cnt - b_inh, INH_EXP);
    check("glitch_done_pulses", done_cnt - b_done, 1);

    // Asynchronous reset in the middle of the data bits.
    samp = '0;
    send_start(8'h00);
    dev_run(3, 1'b0, 1'b0);
    check("midrst_pre_dpull", ps2d_pull, 1);
    check("midrst_pre_busy", busy, 1);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_pulls", {ps2c_pull, ps2d_pull}, 2'b00);
    check("midrst_rdy", rdy, 1);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // Recovery after reset.
    b_done = done_cnt;
    samp = '0;
    send_start(8'hF4);
    dev_run(11, 1'b1, 1'b0);
    wait_done(b_done, 300, "recover_done_seen");
    check("recover_frame", samp, 10'h2F4);
    check("recover_ack_ok", ack_ok, 1);
    check("recover_err", err, 0);

    check("done_only_with_rdy", done_rdy_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter, the sending end of the keyboard/mouse PS/2 link whose receive path already exists. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable reporting) to the attached device using the host-request sequence and checks the device's acknowledge. It drives the open-drain CLK/DAT pads through active-high pull-low enables. It sits beside the PS2/MouseM receivers on the CPU I/O bus, clocked from the 25 MHz system clock.

Parameters:
CLK_HZ, 25000000, system clock frequency; all timing is derived from it
INHIBIT_US, 100, time host holds CLK low before the request
SETUP_CYC, 25, cycles DAT is held low before CLK is released
START_TMO_MS, 15, maximum wait for the device's first falling CLK edge
PKT_TMO_MS, 2, maximum duration from first falling edge to ACK
FILT_LEN, 8, cycles CLK/DAT must be stable before the filtered value changes

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  single-cycle request; accepted only when rdy=1
data  in  8  command byte, latched on an accepted start
rdy  out  1  idle, ready for start
busy  out  1  transfer in progress; also inhibits the PS/2 receiver
done  out  1  one-cycle pulse at the end of a transfer (success or error)
ack_ok  out  1  sticky until next start; device ACKed
err  out  1  sticky until next start; timeout or missing ACK
ps2c_pull  out  1  1 = drive CLK pad low, 0 = release
ps2d_pull  out  1  1 = drive DAT pad low, 0 = release
ps2c_in  in  1  CLK pad level (asynchronous)
ps2d_in  in  1  DAT pad level (asynchronous)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; rdy=1, busy=0, done=0, ack_ok=0, err=0, ps2c_pull=0, ps2d_pull=0. Filters preset to 1. A reset mid-transfer releases both lines immediately.
- Input path: 2-flop synchronizer, then a stability filter of FILT_LEN cycles. fall_c is a one-cycle pulse on a filtered-CLK 1->0 transition.
- Frame: shift register {stop=1, parity, data[7:0]}, LSB first. Parity is odd, computed as ~^data.
- IDLE: when start=1, latch data, clear ack_ok/err, set busy, go to INHIBIT.
- INHIBIT: ps2c_pull=1 for INHIBIT_US*CLK_HZ/1e6 cycles (2500 at default), then go to REQ.
- REQ: ps2c_pull=1 and ps2d_pull=1 (start bit) for SETUP_CYC cycles, then release CLK (ps2c_pull=0) and go to WAIT_CLK. Start the START_TMO counter (375000 cycles at default).
- WAIT_CLK: on the first fall_c, put bit0 on the line (ps2d_pull=~bit), set bit count to 1, start the PKT_TMO counter (50000 cycles), go to BITS.
- BITS: on each fall_c, drive the next bit. Bits 1..7, then parity, then stop (stop releases DAT). After the stop bit is driven, go to ACK. DAT changes only in the cycle after fall_c.
- ACK: ps2d_pull=0. On the next fall_c, sample filtered DAT: 0 sets ack_ok, 1 sets err. Go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered CLK=1 and DAT=1 both hold, then pulse done, clear busy, go to IDLE. The PKT_TMO counter is still active here.
- Timeout in any state: release both lines, set err=1, pulse done, go to IDLE.
- start while busy is ignored and has no effect on data.
- busy = ~rdy at all times. done coincides with the cycle rdy returns to 1.
- All counters saturate; none wraps.

Decomposition:
- Shared package/header ps2_defs: state encoding (IDLE, INHIBIT, REQ, WAIT_CLK, BITS, ACK, WAIT_IDLE), frame length 10, and cycle-count constants derived from the parameters.
- Sub-module ps2_line_filter (synchronizer + stability filter + fall-edge pulse), instantiated twice, for CLK and DAT.

Test Plan:
- Send 0xED to a device model clocking at 12.5 kHz that ACKs -> ps2c_pull high for 2500 cycles; sampled bits are 1,0,1,1,0,1,1,1, parity=1, stop=1; ack_ok=1, err=0, one done pulse.
- Send 0xF4 -> parity bit 0; ack_ok=1.
- Model never clocks -> err=1 and done exactly 375000 cycles after CLK release; both pulls 0.
- Model clocks 11 edges but leaves DAT high on the ACK edge -> err=1, ack_ok=0.
- Model stops after 4 bits -> err=1 at 50000 cycles after the first fall; lines released.
- Assert rst=0 mid-BITS -> pulls drop asynchronously and rdy=1. A start during busy changes nothing; a 3-cycle CLK glitch produces no fall_c.
